// File: rtl/csa_pkg.sv
// csa_pkg: shared state encoding and configuration helpers for the carry-save accumulator.
package csa_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    function automatic int nseg(input int acc_w, input int seg);
        return acc_w / seg;
    endfunction

    function automatic bit cfg_ok(input int w, input int acc_w, input int seg);
        return (acc_w % seg == 0) && (acc_w >= w);
    endfunction
endpackage

// File: rtl/csa_row.sv
// csa_row: N-bit 3:2 compressor; cy is already weighted (shifted left one place, MSB carry dropped).
module csa_row
    import csa_pkg::*;
#(
    parameter int N = 24
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] s,
    output logic [N-1:0] cy
);
    assign cy[0] = 1'b0;
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i] = a[i] ^ b[i] ^ c[i];
        if (i < N - 1) begin : g_cy
            assign cy[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end
endmodule

// File: rtl/csa_accum.sv
// csa_accum: streaming carry-save accumulator with a segmented multi-cycle resolve.
// The running total lives as S/C vectors; only RESOLVE runs a carry chain, SEG bits per cycle.
module csa_accum
    import csa_pkg::*;
#(
    parameter int W      = 16,
    parameter int ACC_W  = 24,
    parameter int SEG    = 8,
    parameter int CNT_W  = 16,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt
);
    localparam int NSEG = nseg(ACC_W, SEG);
    localparam int KW   = $clog2(NSEG + 1);

    if (!cfg_ok(W, ACC_W, SEG)) begin : g_bad_cfg
        $error("csa_accum: ACC_W must be >= W and a multiple of SEG");
    end

    state_t           state, state_nx;
    logic [ACC_W-1:0] s, c, x, row_s, row_c, res;
    logic [KW-1:0]    k;
    logic             cy, acc, sx;
    logic [CNT_W-1:0] cnt;
    logic [SEG:0]     seg_sum;

    assign sx        = (SIGNED != 0) && in_data[W-1];
    assign x         = ACC_W'(in_data) | ({ACC_W{sx}} << W);
    assign in_ready  = (state == IDLE) || (state == ACCUM);
    assign acc       = in_valid && in_ready && !clr;
    assign out_valid = state == DONE;
    assign seg_sum   = {1'b0, s[int'(k)*SEG +: SEG]} + {1'b0, c[int'(k)*SEG +: SEG]} + {{SEG{1'b0}}, cy};

    csa_row #(.N(ACC_W)) u_row (.a(s), .b(c), .c(x), .s(row_s), .cy(row_c));

    // k == NSEG is the extra cycle that publishes the resolved result
    always_comb begin
        state_nx = clr ? IDLE
                 : acc ? (in_last ? RESOLVE : ACCUM)
                 : (state == RESOLVE && k == KW'(NSEG)) ? DONE
                 : (state == DONE && out_ready) ? IDLE
                 : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s       <= '0;
            c       <= '0;
            res     <= '0;
            cy      <= 1'b0;
            k       <= '0;
            cnt     <= '0;
            out_sum <= '0;
            out_cnt <= '0;
        end else if (clr) begin
            s   <= '0;
            c   <= '0;
            cy  <= 1'b0;
            k   <= '0;
            cnt <= '0;
        end else begin
            if (acc) begin
                s   <= row_s;
                c   <= row_c;
                cnt <= (&cnt) ? cnt : cnt + 1'b1;
                k   <= '0;
                cy  <= 1'b0;
            end
            if (state == RESOLVE) begin
                if (k == KW'(NSEG)) begin
                    out_sum <= res;
                    out_cnt <= cnt;
                end else begin
                    res[int'(k)*SEG +: SEG] <= seg_sum[SEG-1:0];
                    cy <= seg_sum[SEG];
                    k  <= k + 1'b1;
                end
            end
            if (state == DONE && out_ready) begin
                s   <= '0;
                c   <= '0;
                cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_csa_accum.sv
// tb_csa_accum: directed scoreboard bench; an unsigned and a signed instance share one stimulus stream.
module tb_csa_accum;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready0, in_ready1, out_valid0, out_valid1;
    logic [23:0] out_sum0, out_sum1;
    logic [15:0] out_cnt0, out_cnt1;

    typedef struct {
        logic [23:0] s0;
        logic [23:0] s1;
        logic [15:0] n;
    } exp_t;

    exp_t        q[$];
    logic [23:0] m0 = '0, m1 = '0, last_s0 = '0;
    logic [15:0] mn = '0;
    int          passed = 0, total = 0;

    always #5 clk = ~clk;

    csa_accum #(.W(16), .ACC_W(24), .SEG(8), .CNT_W(16), .SIGNED(0)) u0 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready),
        .out_sum(out_sum0), .out_cnt(out_cnt0)
    );

    csa_accum #(.W(16), .ACC_W(24), .SEG(8), .CNT_W(16), .SIGNED(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready),
        .out_sum(out_sum1), .out_cnt(out_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_acc(input logic [15:0] d, input bit last);
        exp_t e;
        m0 = m0 + {8'h00, d};
        m1 = m1 + {{8{d[15]}}, d};
        mn = (mn == 16'hFFFF) ? mn : mn + 16'd1;
        if (last) begin
            e.s0 = m0;
            e.s1 = m1;
            e.n  = mn;
            q.push_back(e);
            m0 = '0;
            m1 = '0;
            mn = '0;
        end
    endtask

    task automatic send(input logic [15:0] d, input bit last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) chk("send_ready_timeout", 32'(in_ready0), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_acc(d, last);
    endtask

    task automatic collect(input int hold);
        int   n = 0;
        exp_t e;
        out_ready = (hold == 0);
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid0 && n < 20);
        chk("latency", 32'(n), 32'd4);
        chk("out_valid_signed", 32'(out_valid1), 32'd1);
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'(q.size()), 32'd1);
        end else begin
            e = q.pop_front();
            chk("sum_unsigned", 32'(out_sum0), 32'(e.s0));
            chk("sum_signed", 32'(out_sum1), 32'(e.s1));
            chk("cnt_unsigned", 32'(out_cnt0), 32'(e.n));
            chk("cnt_signed", 32'(out_cnt1), 32'(e.n));
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                chk("bp_valid", 32'(out_valid0), 32'd1);
                chk("bp_sum", 32'(out_sum0), 32'(e.s0));
                chk("bp_cnt", 32'(out_cnt0), 32'(e.n));
                chk("bp_in_ready", 32'(in_ready0), 32'd0);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk("post_valid", 32'(out_valid0), 32'd0);
            chk("post_in_ready", 32'(in_ready0), 32'd1);
            chk("post_sum_held", 32'(out_sum0), 32'(e.s0));
            chk("post_cnt_held", 32'(out_cnt0), 32'(e.n));
            last_s0 = e.s0;
        end
    endtask

    initial begin
        #2;
        chk("rst_valid", 32'(out_valid0), 32'd0);
        chk("rst_in_ready", 32'(in_ready0), 32'd1);
        chk("rst_sum", 32'(out_sum0), 32'd0);
        chk("rst_cnt", 32'(out_cnt0), 32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        send(16'h0003, 1'b1);
        collect(0);

        for (int i = 0; i < 256; i++) send(16'hFFFF, i == 255);
        collect(0);
        for (int i = 0; i < 257; i++) send(16'hFFFF, i == 256);
        collect(0);

        send(16'hFFFF, 1'b0);
        send(16'h0001, 1'b1);
        collect(0);
        send(16'hFFFF, 1'b1);
        collect(0);
        send(16'h8000, 1'b0);
        send(16'h8000, 1'b1);
        collect(0);

        // backpressure with an operand waiting at the input the whole time
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'h0009;
        in_last  = 1'b1;
        collect(5);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_acc(16'h0009, 1'b1);
        collect(0);

        send(16'h0001, 1'b0);
        send(16'h0002, 1'b1);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        void'(q.pop_back());
        chk("clr_sum_kept", 32'(out_sum0), 32'(last_s0));
        chk("clr_in_ready", 32'(in_ready0), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("clr_no_valid", 32'(out_valid0), 32'd0);
        end
        send(16'h0005, 1'b0);
        send(16'h0007, 1'b1);
        collect(0);

        send(16'h0003, 1'b0);
        send(16'h0004, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid0), 32'd0);
        chk("arst_sum", 32'(out_sum0), 32'd0);
        chk("arst_cnt", 32'(out_cnt0), 32'd0);
        chk("arst_sum_signed", 32'(out_sum1), 32'd0);
        #1 rst = 1'b0;
        m0 = '0;
        m1 = '0;
        mn = '0;
        send(16'h0010, 1'b1);
        collect(0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
